// File: rtl/qfixed_seq_divider.sv
// qfixed_seq_divider: sequential signed Q(WIDTH-1-FRAC).FRAC restoring divider with NaN/+-inf/zero encodings.
// Define QDIV_ROUND_EN for round-half-away-from-zero via one extra guard quotient bit.
module qfixed_seq_divider #(
   parameter int WIDTH = 64,
   parameter int FRAC  = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             launch,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             nan,
   output logic [WIDTH-1:0] res
);
`ifdef QDIV_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif
   localparam int NI = WIDTH + FRAC + RND;
   localparam int CW = $clog2(NI + 1);
   localparam logic [WIDTH-1:0] NAN_V = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] INF_P = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] INF_N = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
   localparam logic [NI-1:0] MAX_M = {{(NI-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {IDLE = 2'd0, ITER, FIN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [NI-1:0]    dq_q, dq_d;
   logic [WIDTH-1:0] bm_q, bm_d, pres_q, pres_d, res_q, res_d;
   logic             sgn_q, sgn_d, spec_q, spec_d, pnan_q, pnan_d, nan_q, nan_d, done_q, done_d;
   logic [WIDTH-1:0] am_c, bm_c;
   logic [WIDTH:0]   t_c;
   logic [NI-1:0]    mag_c;
   logic             ge_c, a_nan, b_nan, a_inf, b_inf, sp_nan, spec_c, neg_c, sat_c;

   assign am_c   = a[WIDTH-1] ? -a : a;
   assign bm_c   = b[WIDTH-1] ? -b : b;
   assign a_nan  = a == NAN_V;
   assign b_nan  = b == NAN_V;
   assign a_inf  = (a == INF_P) || (a == INF_N);
   assign b_inf  = (b == INF_P) || (b == INF_N);
   assign neg_c  = a[WIDTH-1] ^ b[WIDTH-1];
   assign sp_nan = a_nan | b_nan | (b == '0) | (a_inf & b_inf);
   assign spec_c = sp_nan | a_inf | b_inf | (a == '0);
   // dq holds the dividend shifting out MSB-first while quotient bits shift in at the LSB
   assign t_c    = {rem_q[WIDTH-1:0], dq_q[NI-1]};
   assign ge_c   = rem_q[WIDTH] | (t_c >= {1'b0, bm_q});
   assign mag_c  = (dq_q >> RND) + {{(NI-1){1'b0}}, dq_q[0] & (RND == 1)};
   assign sat_c  = mag_c >= MAX_M;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dq_d    = dq_q;
      bm_d    = bm_q;
      sgn_d   = sgn_q;
      spec_d  = spec_q;
      pres_d  = pres_q;
      pnan_d  = pnan_q;
      res_d   = res_q;
      nan_d   = nan_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (launch) begin
            sgn_d   = neg_c;
            spec_d  = spec_c;
            pnan_d  = sp_nan;
            pres_d  = sp_nan ? NAN_V : a_inf ? (neg_c ? INF_N : INF_P) : '0;
            rem_d   = '0;
            dq_d    = {{(NI-WIDTH){1'b0}}, am_c} << (FRAC + RND);
            bm_d    = bm_c;
            cnt_d   = CW'(NI);
            state_d = spec_c ? FIN : ITER;
         end
         ITER: begin
            rem_d   = ge_c ? t_c - {1'b0, bm_q} : t_c;
            dq_d    = {dq_q[NI-2:0], ge_c};
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? FIN : ITER;
         end
         FIN: begin
            res_d   = spec_q ? pres_q : sat_c ? (sgn_q ? INF_N : INF_P)
                    : sgn_q ? -mag_c[WIDTH-1:0] : mag_c[WIDTH-1:0];
            nan_d   = spec_q & pnan_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dq_q    <= '0;
         bm_q    <= '0;
         sgn_q   <= 1'b0;
         spec_q  <= 1'b0;
         pres_q  <= '0;
         pnan_q  <= 1'b0;
         res_q   <= '0;
         nan_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dq_q    <= dq_d;
         bm_q    <= bm_d;
         sgn_q   <= sgn_d;
         spec_q  <= spec_d;
         pres_q  <= pres_d;
         pnan_q  <= pnan_d;
         res_q   <= res_d;
         nan_q   <= nan_d;
         done_q  <= done_d;
      end
   end

   assign busy = state_q != IDLE;
   assign done = done_q;
   assign nan  = nan_q;
   assign res  = res_q;
endmodule

// File: tb/tb_qfixed_seq_divider.sv
// tb_qfixed_seq_divider: directed and random checks of qfixed_seq_divider (WIDTH=64, FRAC=15).
// Honours QDIV_ROUND_EN the same way the design does.
module tb_qfixed_seq_divider;
   localparam int WIDTH = 64;
   localparam int FRAC  = 15;
`ifdef QDIV_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif
   localparam int NLAT = WIDTH + FRAC + 2 + RND;
   localparam logic [63:0] NANV = 64'h8000_0000_0000_0000;
   localparam logic [63:0] INFP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] INFN = 64'h8000_0000_0000_0001;
   localparam logic [63:0] THIRD = RND ? 64'h2AAB : 64'h2AAA;

   logic        clk = 1'b0, reset = 1'b1, launch = 1'b0;
   logic [63:0] a = '0, b = '0;
   logic        busy, done, nan;
   logic [63:0] res;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   qfixed_seq_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dut (
      .clk(clk), .reset(reset), .launch(launch), .a(a), .b(b),
      .busy(busy), .done(done), .nan(nan), .res(res)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Reference: real-valued quotient scaled by 2^FRAC, truncated or rounded half away from zero.
   function automatic void model(input logic [63:0] x, input logic [63:0] y,
                                 output logic [63:0] r, output logic n, output int lat);
      logic [63:0]  ax, ay;
      logic [127:0] ma, mb, q;
      logic         xi, yi, neg;
      xi  = (x == INFP) || (x == INFN);
      yi  = (y == INFP) || (y == INFN);
      neg = x[63] ^ y[63];
      n   = 1'b0;
      lat = 2;
      r   = '0;
      if (x == NANV || y == NANV || y == '0 || (xi && yi)) begin
         r = NANV;
         n = 1'b1;
      end else if (xi) r = neg ? INFN : INFP;
      else if (yi || x == '0) r = '0;
      else begin
         lat = NLAT;
         ax  = x[63] ? -x : x;
         ay  = y[63] ? -y : y;
         ma  = {64'd0, ax};
         mb  = {64'd0, ay};
         q   = RND ? ((ma << (FRAC + 1)) + mb) / (mb << 1) : (ma << FRAC) / mb;
         if (q >= {64'd0, INFP}) r = neg ? INFN : INFP;
         else r = neg ? -q[63:0] : q[63:0];
      end
   endfunction

   function automatic logic [63:0] rnd_op();
      logic [63:0] v;
      int          k;
      k = int'($urandom_range(0, 11));
      v = {$urandom, $urandom} >> $urandom_range(0, 62);
      if (k == 0) v = NANV;
      else if (k == 1) v = INFP;
      else if (k == 2) v = '0;
      if ($urandom_range(0, 1) == 1) v = -v;
      return v;
   endfunction

   task automatic launch_op(input logic [63:0] x, input logic [63:0] y);
      @(negedge clk);
      chk("done_low_before_launch", 64'(done), 64'(0));
      a = x;
      b = y;
      launch = 1'b1;
      @(negedge clk);
      launch = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      chk("busy_after_launch", 64'(busy), 64'(1));
   endtask

   task automatic finish_op(input string tag, input logic [63:0] x, input logic [63:0] y);
      logic [63:0] er;
      logic        en;
      int          el, lat;
      model(x, y, er, en, el);
      lat = 1;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 400);
      chk({tag, "_done"}, 64'(done), 64'(1));
      chk({tag, "_lat"}, 64'(lat), 64'(el));
      chk({tag, "_res"}, res, er);
      chk({tag, "_nan"}, 64'(nan), 64'(en));
      chk({tag, "_busy_low"}, 64'(busy), 64'(0));
   endtask

   task automatic do_op(input string tag, input logic [63:0] x, input logic [63:0] y);
      launch_op(x, y);
      finish_op(tag, x, y);
   endtask

   initial begin
      logic [63:0] hres, er;
      logic        en;
      int          nd, dl, el;
      #12;
      chk("reset_ctl", {61'd0, busy, done, nan}, 64'd0);
      chk("reset_res", res, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      do_op("div3_2", 64'h18000, 64'h10000);
      chk("div3_2_const", res, 64'hC000);
      do_op("div1_3", 64'h8000, 64'h18000);
      chk("div1_3_const", res, THIRD);
      do_op("divm1_3", -64'h8000, 64'h18000);
      chk("divm1_3_const", res, -THIRD);
      do_op("sp_bzero", 64'h8000, 64'h0);
      chk("sp_bzero_const", res, NANV);
      do_op("sp_infinf", INFP, INFN);
      do_op("sp_ninf", INFN, 64'h10000);
      chk("sp_ninf_const", res, INFN);
      do_op("sp_binf", 64'h28000, INFP);
      chk("sp_binf_const", res, 64'h0);
      do_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFE, 64'h1);
      chk("ovf_pos_const", res, INFP);
      do_op("ovf_neg", 64'h7FFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("ovf_neg_const", res, INFN);

      for (int k = 0; k < 30; k++) do_op("rand", rnd_op(), rnd_op());

      // Launches at cycles 5 and 40 of a running division must be ignored.
      launch_op(64'h18000, 64'h10000);
      nd = 0;
      dl = 0;
      hres = '0;
      for (int i = 2; i <= 200; i++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            dl = i;
            hres = res;
         end
         launch = (i == 5 || i == 40);
         if (launch) begin
            a = 64'h8000;
            b = 64'h18000;
         end
      end
      launch = 1'b0;
      chk("hs_one_done", 64'(nd), 64'(1));
      chk("hs_lat", 64'(dl), 64'(NLAT));
      chk("hs_res", hres, 64'hC000);

      // A launch presented in the done cycle is accepted.
      launch_op(64'h18000, 64'h10000);
      finish_op("dc_first", 64'h18000, 64'h10000);
      a = 64'h8000;
      b = 64'h18000;
      launch = 1'b1;
      @(negedge clk);
      launch = 1'b0;
      chk("dc_busy_rise", 64'(busy), 64'(1));
      finish_op("dc_second", 64'h8000, 64'h18000);

      // Asynchronous abort mid-division.
      model(64'h8000, 64'h18000, er, en, el);
      launch_op(64'h18000, 64'h10000);
      repeat (28) @(negedge clk);
      chk("held_res", res, er);
      #2 reset = 1'b1;
      #1;
      chk("abort_ctl", {61'd0, busy, done, nan}, 64'd0);
      chk("abort_res", res, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort_no_done", 64'(nd), 64'(0));
      do_op("after_abort", 64'h18000, 64'h10000);
      chk("after_abort_const", res, 64'hC000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
